gerenciador_atributos: RTL and testbench

GERENCIADOR_ATRIBUTOS -- requirements
Module: gerenciador_atributos

---
 rtl/atributos_pkg.sv | 25 ++
 rtl/atributo_saturado.sv | 60 ++++++
 rtl/gerenciador_atributos.sv | 89 ++++++++
 tb/tb_gerenciador_atributos.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/atributos_pkg.sv
// Shared defaults for the virtual-pet attribute manager: thresholds, step sizes,
// saturation ceiling, attribute indices and the prescaler width helper.
package atributos_pkg;

    typedef enum int {
        FOME       = 0,
        FELICIDADE = 1,
        SONO       = 2
    } indice_atrib_e;

    localparam int N_ATRIB_PAD       = 3;
    localparam int LARGURA_PAD       = 8;
    localparam int MAX_VALOR_PAD     = 100;
    localparam int DIV_TICK_PAD      = 256;
    localparam int VEL_SUBIDA_PAD    = 7;
    localparam int VEL_DESCIDA_PAD   = 1;
    localparam int LIMIAR_MORTE_PAD  = 10;
    localparam int LIMIAR_ALERTA_PAD = 25;

    // A divide-by-one prescaler still needs one bit to exist.
    function automatic int largura_presc(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/atributo_saturado.sv
// One attribute: a saturating register that rises, holds or decays on each update,
// with a registered alert flag and a combinational death-threshold flag on the new value.
module atributo_saturado #(
    parameter int                 LARGURA       = 8,
    parameter int                 MAX_VALOR     = 100,
    parameter int                 VEL_SUBIDA    = 7,
    parameter int                 VEL_DESCIDA   = 1,
    parameter int                 LIMIAR_MORTE  = 10,
    parameter int                 LIMIAR_ALERTA = 25,
    parameter logic [LARGURA-1:0] VALOR_INICIAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               atualiza,
    input  logic               sobe,
    input  logic               congela,
    output logic [LARGURA-1:0] valor,
    output logic               alerta,
    output logic               critico
);

    localparam logic [LARGURA:0] MAX_EXT    = (LARGURA+1)'(MAX_VALOR);
    localparam logic [LARGURA:0] SUB_EXT    = (LARGURA+1)'(VEL_SUBIDA);
    localparam logic [LARGURA:0] DESC_EXT   = (LARGURA+1)'(VEL_DESCIDA);
    localparam logic [LARGURA:0] MORTE_EXT  = (LARGURA+1)'(LIMIAR_MORTE);
    localparam logic [LARGURA:0] ALERTA_EXT = (LARGURA+1)'(LIMIAR_ALERTA);

    logic [LARGURA-1:0] valor_reg;
    logic               alerta_reg;
    logic [LARGURA:0]   atual_ext;
    logic [LARGURA:0]   calc_ext;
    logic [LARGURA-1:0] valor_next;

    // One extra bit keeps both bounds free of wrap-around; the result never exceeds MAX_VALOR.
    always_comb begin
        atual_ext = {1'b0, valor_reg};
        calc_ext  = atual_ext;
        if (sobe) begin
            calc_ext = (atual_ext > MAX_EXT - SUB_EXT) ? MAX_EXT : atual_ext + SUB_EXT;
        end else if (!congela) begin
            calc_ext = (atual_ext < DESC_EXT) ? '0 : atual_ext - DESC_EXT;
        end
        valor_next = atualiza ? calc_ext[LARGURA-1:0] : valor_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valor_reg  <= VALOR_INICIAL;
            alerta_reg <= ({1'b0, VALOR_INICIAL} <= ALERTA_EXT);
        end else begin
            valor_reg  <= valor_next;
            alerta_reg <= ({1'b0, valor_next} <= ALERTA_EXT);
        end
    end

    assign valor   = valor_reg;
    assign alerta  = alerta_reg;
    assign critico = ({1'b0, valor_next} <= MORTE_EXT);

endmodule

// File: rtl/gerenciador_atributos.sv
// Attribute manager: a tick prescaler drives periodic updates of N saturating
// attributes; any attribute reaching the death threshold freezes everything until reset.
module gerenciador_atributos
    import atributos_pkg::*;
#(
    parameter int                         N_ATRIB       = N_ATRIB_PAD,
    parameter int                         LARGURA       = LARGURA_PAD,
    parameter int                         MAX_VALOR     = MAX_VALOR_PAD,
    parameter int                         DIV_TICK      = DIV_TICK_PAD,
    parameter int                         VEL_SUBIDA    = VEL_SUBIDA_PAD,
    parameter int                         VEL_DESCIDA   = VEL_DESCIDA_PAD,
    parameter int                         LIMIAR_MORTE  = LIMIAR_MORTE_PAD,
    parameter int                         LIMIAR_ALERTA = LIMIAR_ALERTA_PAD,
    parameter logic [N_ATRIB*LARGURA-1:0] VALOR_INICIAL = {8'd50, 8'd70, 8'd80}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_ATRIB-1:0]           sobe,
    input  logic [N_ATRIB-1:0]           congela,
    input  logic                         pausa,
    output logic [N_ATRIB*LARGURA-1:0]   atributos,
    output logic [N_ATRIB-1:0]           alerta,
    output logic                         tick,
    output logic                         morreu
);

    localparam int             PW        = largura_presc(DIV_TICK);
    localparam logic [PW-1:0]  PRESC_FIM = PW'(DIV_TICK - 1);

    if (MAX_VALOR >= (1 << LARGURA)) begin : g_erro_max
        $error("MAX_VALOR must fit in LARGURA bits");
    end
    if (DIV_TICK < 1) begin : g_erro_div
        $error("DIV_TICK must be at least 1");
    end
    if (VEL_SUBIDA > MAX_VALOR || VEL_DESCIDA > MAX_VALOR) begin : g_erro_vel
        $error("step sizes must not exceed MAX_VALOR");
    end

    logic [PW-1:0]      presc_reg;
    logic               tick_reg;
    logic               morreu_reg;
    logic               qualifica;
    logic [N_ATRIB-1:0] critico;

    assign qualifica = !pausa && !morreu_reg && (presc_reg == PRESC_FIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_reg  <= '0;
            tick_reg   <= 1'b0;
            morreu_reg <= 1'b0;
        end else begin
            tick_reg <= qualifica;
            if (qualifica) begin
                presc_reg  <= '0;
                morreu_reg <= |critico;
            end else if (!pausa && !morreu_reg) begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end

    // sobe/congela only matter in the qualifying cycle; the slices ignore them otherwise.
    for (genvar gi = 0; gi < N_ATRIB; gi++) begin : g_atrib
        atributo_saturado #(
            .LARGURA       (LARGURA),
            .MAX_VALOR     (MAX_VALOR),
            .VEL_SUBIDA    (VEL_SUBIDA),
            .VEL_DESCIDA   (VEL_DESCIDA),
            .LIMIAR_MORTE  (LIMIAR_MORTE),
            .LIMIAR_ALERTA (LIMIAR_ALERTA),
            .VALOR_INICIAL (VALOR_INICIAL[gi*LARGURA +: LARGURA])
        ) u_atrib (
            .clk      (clk),
            .rst_n    (rst_n),
            .atualiza (qualifica),
            .sobe     (sobe[gi]),
            .congela  (congela[gi]),
            .valor    (atributos[gi*LARGURA +: LARGURA]),
            .alerta   (alerta[gi]),
            .critico  (critico[gi])
        );
    end

    assign tick   = tick_reg;
    assign morreu = morreu_reg;

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Directed bench for gerenciador_atributos with DIV_TICK=4: reset, decay, saturation,
// hold, pause, death freeze and restart after death.
module tb_gerenciador_atributos;
    import atributos_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  sobe = '0;
    logic [2:0]  congela = '0;
    logic        pausa = 1'b0;
    logic [23:0] atributos;
    logic [2:0]  alerta;
    logic        tick;
    logic        morreu;

    int n_checks = 0;
    int n_fails  = 0;
    int n_tick   = 0;
    int e_f, e_h, e_s;

    gerenciador_atributos #(.DIV_TICK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sobe      (sobe),
        .congela   (congela),
        .pausa     (pausa),
        .atributos (atributos),
        .alerta    (alerta),
        .tick      (tick),
        .morreu    (morreu)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int campo(input logic [23:0] v, input int i);
        return int'(v[i*8 +: 8]);
    endfunction

    function automatic int sat_sobe(input int v);
        return (v > 93) ? 100 : v + 7;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vals(input string tag);
        check({tag, "_fome"}, campo(atributos, FOME), e_f);
        check({tag, "_felicidade"}, campo(atributos, FELICIDADE), e_h);
        check({tag, "_sono"}, campo(atributos, SONO), e_s);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 16);
        check({tag, "_tick"}, tick, 1);
        n_tick++;
        $display("tick %0d %s: fome=%0d felicidade=%0d sono=%0d alerta=%b morreu=%b",
                 n_tick, tag, campo(atributos, FOME), campo(atributos, FELICIDADE),
                 campo(atributos, SONO), alerta, morreu);
    endtask

    initial begin
        // Reset state
        step();
        check("rst_atributos", atributos, 24'h324650);
        check("rst_alerta", alerta, 3'b000);
        check("rst_morreu", morreu, 0);
        check("rst_tick", tick, 0);
        rst_n = 1'b1;

        // Plain decay: tick on the 4th edge, one cycle wide
        step(); step(); step();
        check("decay_no_early_tick", tick, 0);
        step();
        check("decay_tick", tick, 1);
        e_f = 79; e_h = 69; e_s = 49;
        check_vals("decay");
        step();
        check("decay_tick_one_cycle", tick, 0);

        // Saturation and sobe-over-congela priority from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sobe = 3'b110; congela = 3'b010;
        wait_tick("rise1");
        e_f = 79; e_h = 77; e_s = 57;
        check_vals("rise1");
        sobe = 3'b100; congela = 3'b000;
        for (int k = 2; k <= 9; k++) begin
            wait_tick("rise");
            e_f--; e_h--; e_s = sat_sobe(e_s);
            check_vals("rise");
        end
        check("sat_sono_ceiling", campo(atributos, SONO), 100);

        // Hold: congela on fome only
        sobe = 3'b000; congela = 3'b001;
        wait_tick("hold");
        e_h--; e_s--;
        check_vals("hold");
        congela = 3'b000;

        // Pause across prescaler==3
        step(); step(); step();
        check("pause_pre_tick", tick, 0);
        pausa = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("pause_no_tick", tick, 0);
        end
        check_vals("pause_frozen");
        pausa = 1'b0;
        step();
        check("pause_release_tick", tick, 1);
        e_f--; e_h--; e_s--;
        check_vals("pause_release");

        // Death: fome decays to the threshold while the others climb
        sobe = 3'b110;
        while (e_f > 11) begin
            wait_tick("decline");
            e_f--; e_h = sat_sobe(e_h); e_s = sat_sobe(e_s);
            check_vals("decline");
            if (e_f == 26) check("alerta_above", alerta[FOME], 0);
            if (e_f == 25) check("alerta_at", alerta[FOME], 1);
            check("decline_alive", morreu, 0);
        end
        wait_tick("death");
        e_f = 10;
        check_vals("death");
        check("death_morreu", morreu, 1);
        check("death_alerta", alerta, 3'b001);
        for (int k = 0; k < 20; k++) begin
            step();
            check("dead_no_tick", tick, 0);
            check("dead_frozen", atributos, {8'(e_s), 8'(e_h), 8'(e_f)});
            check("dead_sticky", morreu, 1);
        end

        // Reset after death restarts everything
        sobe = 3'b000;
        rst_n = 1'b0;
        step();
        check("rerst_atributos", atributos, 24'h324650);
        check("rerst_alerta", alerta, 3'b000);
        check("rerst_morreu", morreu, 0);
        check("rerst_tick", tick, 0);
        rst_n = 1'b1;
        step(); step(); step();
        check("rerst_no_early_tick", tick, 0);
        step();
        check("rerst_tick_resumes", tick, 1);
        e_f = 79; e_h = 69; e_s = 49;
        check_vals("rerst_decay");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
